// File: rtl/lap_record_ctrl_pkg.sv
// Shared types and constants for the lap-record controller slice.
// Holds the view-state encoding, storage depth and default tick periods.
package lap_record_ctrl_pkg;

    typedef enum logic [1:0] {
        LIVE      = 2'd0,
        VIEW_MAN  = 2'd1,
        VIEW_AUTO = 2'd2
    } state_t;

    localparam int MAX_LAPS         = 16;
    localparam int CNT_W            = 5;
    localparam int TICK_W           = 6;
    localparam int DEF_AUTO_PERIOD  = 2;
    localparam int DEF_IDLE_TIMEOUT = 10;

    // Storage occupancy never wraps; it holds at MAX_LAPS.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v < CNT_W'(MAX_LAPS)) begin
            r = v + CNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_record_ctrl_if.sv
// Key/status inputs and storage strobes of the lap-record controller.
// The controller side uses the slave modport; the key/stopwatch side uses master.
interface lap_record_ctrl_if;
    import lap_record_ctrl_pkg::*;

    logic             tick_1hz;
    logic             key_lap;
    logic             key_view;
    logic             key_next;
    logic             key_auto;
    logic             run_en;
    logic             store_flag;
    logic             read_flag;
    logic             sta_sto_flag;
    logic             disp_mode;
    logic             auto_on;
    logic [CNT_W-1:0] stored_cnt;
    logic             lap_reject;
    logic             view_reject;

    modport master (
        output tick_1hz, key_lap, key_view, key_next, key_auto, run_en,
        input  store_flag, read_flag, sta_sto_flag, disp_mode, auto_on,
               stored_cnt, lap_reject, view_reject
    );

    modport slave (
        input  tick_1hz, key_lap, key_view, key_next, key_auto, run_en,
        output store_flag, read_flag, sta_sto_flag, disp_mode, auto_on,
               stored_cnt, lap_reject, view_reject
    );

endinterface

// File: rtl/lap_record_ctrl_tick.sv
// Generic tick counter: counts tick pulses up to TERMINAL and flags the expiring tick.
// done is decoded from the registered count so the caller can register its strobe next edge.
module tick_event_counter
    import lap_record_ctrl_pkg::*;
#(
    parameter int TERMINAL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TERMINAL - 1);

    logic [TICK_W-1:0] cnt_r;

    // A clear in the same cycle as a tick wins and suppresses the expiry.
    assign done = tick & ~clr & (cnt_r == LAST);

    // Tick count, wrapping to zero on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= TICK_W'(0);
        end else if (clr) begin
            cnt_r <= TICK_W'(0);
        end else if (tick) begin
            if (cnt_r == LAST) begin
                cnt_r <= TICK_W'(0);
            end else begin
                cnt_r <= cnt_r + TICK_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/lap_record_ctrl.sv
// Lap-record sequencer: turns key pulses into store / display-toggle / next-item strobes,
// with manual and auto-scroll browsing of stored laps and an idle return to live display.
module lap_record_ctrl
    import lap_record_ctrl_pkg::*;
#(
    parameter int AUTO_PERIOD  = DEF_AUTO_PERIOD,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    lap_record_ctrl_if.slave   bus
);

    state_t           state_r;
    logic             store_r;
    logic             read_r;
    logic             next_r;
    logic             disp_r;
    logic             auto_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lap_rej_r;
    logic             view_rej_r;
    logic             pending_r;

    logic any_key_s;
    logic view_req_s;
    logic idle_clr_s;
    logic per_clr_s;
    logic idle_done_s;
    logic per_done_s;

    assign any_key_s  = bus.key_lap | bus.key_view | bus.key_next | bus.key_auto;
    assign view_req_s = bus.key_view | pending_r;
    // Counters sit at zero outside their own state, so entering a state starts a fresh count.
    assign idle_clr_s = (state_r != VIEW_MAN) | any_key_s;
    assign per_clr_s  = (state_r != VIEW_AUTO) | bus.key_next | bus.key_view | bus.key_auto;

    tick_event_counter #(.TERMINAL(IDLE_TIMEOUT)) u_idle (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .clr   (idle_clr_s),
        .tick  (bus.tick_1hz),
        .done  (idle_done_s)
    );

    tick_event_counter #(.TERMINAL(AUTO_PERIOD)) u_period (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .clr   (per_clr_s),
        .tick  (bus.tick_1hz),
        .done  (per_done_s)
    );

    // View FSM with registered strobes and status outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= LIVE;
            store_r    <= 1'b0;
            read_r     <= 1'b0;
            next_r     <= 1'b0;
            disp_r     <= 1'b0;
            auto_r     <= 1'b0;
            cnt_r      <= CNT_W'(0);
            lap_rej_r  <= 1'b0;
            view_rej_r <= 1'b0;
            pending_r  <= 1'b0;
        end else begin
            store_r    <= 1'b0;
            read_r     <= 1'b0;
            next_r     <= 1'b0;
            lap_rej_r  <= 1'b0;
            view_rej_r <= 1'b0;
            pending_r  <= 1'b0;
            case (state_r)
                LIVE: begin
                    if (bus.key_lap) begin
                        // Lap goes first; a coincident view is re-evaluated next cycle.
                        if (bus.run_en && (cnt_r < CNT_W'(MAX_LAPS))) begin
                            store_r <= 1'b1;
                            cnt_r   <= sat_inc(cnt_r);
                        end else begin
                            lap_rej_r <= 1'b1;
                        end
                        pending_r <= view_req_s;
                    end else if (view_req_s) begin
                        if (cnt_r != CNT_W'(0)) begin
                            read_r  <= 1'b1;
                            disp_r  <= 1'b1;
                            state_r <= VIEW_MAN;
                        end else begin
                            view_rej_r <= 1'b1;
                        end
                    end else begin
                        state_r <= LIVE;
                    end
                end
                VIEW_MAN: begin
                    lap_rej_r <= bus.key_lap;
                    if (bus.key_view || idle_done_s) begin
                        read_r  <= 1'b1;
                        disp_r  <= 1'b0;
                        state_r <= LIVE;
                    end else if (bus.key_auto) begin
                        auto_r  <= 1'b1;
                        state_r <= VIEW_AUTO;
                    end else if (bus.key_next) begin
                        next_r <= 1'b1;
                    end else begin
                        state_r <= VIEW_MAN;
                    end
                end
                VIEW_AUTO: begin
                    lap_rej_r <= bus.key_lap;
                    if (bus.key_view) begin
                        read_r  <= 1'b1;
                        disp_r  <= 1'b0;
                        auto_r  <= 1'b0;
                        state_r <= LIVE;
                    end else if (bus.key_auto) begin
                        auto_r  <= 1'b0;
                        state_r <= VIEW_MAN;
                    end else if (bus.key_next || per_done_s) begin
                        next_r <= 1'b1;
                    end else begin
                        state_r <= VIEW_AUTO;
                    end
                end
                default: begin
                    state_r <= LIVE;
                    disp_r  <= 1'b0;
                    auto_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.store_flag   = store_r;
    assign bus.read_flag    = read_r;
    assign bus.sta_sto_flag = next_r;
    assign bus.disp_mode    = disp_r;
    assign bus.auto_on      = auto_r;
    assign bus.stored_cnt   = cnt_r;
    assign bus.lap_reject   = lap_rej_r;
    assign bus.view_reject  = view_rej_r;

endmodule

// File: doc/lap_record_ctrl.md
Name: lap_record_ctrl

Overview:
Controller that sequences the lap-record storage/readback datapath of the digital clock. It turns debounced key pulses and stopwatch status into the single-cycle store, display-toggle and next-item strobes that the storage block consumes. It rejects illegal requests and provides manual and auto-scroll browsing of stored laps, with an idle timeout back to live display. It sits between the key debouncers and the lap storage block.

Parameters:
MAX_LAPS, 16, storage depth; stored count saturates here
AUTO_PERIOD, 2, tick_1hz pulses between auto-advance strobes (1..15)
IDLE_TIMEOUT, 10, tick_1hz pulses without a key in manual view before returning to live (1..63)

Ports:
sys_clk  in  1  system clock
rst_n  in  1  async active-low reset
tick_1hz  in  1  one-cycle pulse per second
key_lap  in  1  debounced pulse: record current time
key_view  in  1  debounced pulse: enter/leave history view
key_next  in  1  debounced pulse: show next stored lap
key_auto  in  1  debounced pulse: toggle auto-scroll (view only)
run_en  in  1  stopwatch running
store_flag  out  1  one-cycle store strobe to storage
read_flag  out  1  one-cycle display-mode toggle strobe to storage
sta_sto_flag  out  1  one-cycle next-item strobe to storage
disp_mode  out  1  mirror of storage display mode (1 = history)
auto_on  out  1  high in VIEW_AUTO
stored_cnt  out  5  laps stored, 0..MAX_LAPS
lap_reject  out  1  one-cycle pulse on a refused lap request
view_reject  out  1  one-cycle pulse on a refused view entry

Behaviour:
- Interface: one clock, sys_clk; reset rst_n is asynchronous, active-low. On reset: state LIVE; all strobes 0; disp_mode 0; auto_on 0; stored_cnt 0; period and idle counters 0; pending_view 0.
- All outputs are registered. Strobes assert the cycle after the causing input pulse and last exactly one cycle.
- At most one of store_flag, read_flag and sta_sto_flag is high in any cycle.
- States: LIVE, VIEW_MAN, VIEW_AUTO. disp_mode = (state != LIVE).
- LIVE, key_lap:
  - If run_en=1 and stored_cnt<MAX_LAPS: store_flag and stored_cnt+1.
  - Otherwise: lap_reject.
- LIVE, key_view:
  - If stored_cnt!=0: read_flag, go to VIEW_MAN, idle counter cleared.
  - If stored_cnt==0: view_reject, stay in LIVE.
- LIVE, key_lap and key_view in the same cycle: the lap is handled first. The view request is latched in pending_view and evaluated the next cycle against the updated stored_cnt, so read_flag appears 2 cycles after the keys.
- LIVE: key_next and key_auto are ignored.
- VIEW_MAN, key priority view > auto > next; at most one key acts per cycle:
  - key_view: read_flag, go to LIVE.
  - key_auto: go to VIEW_AUTO, period counter cleared.
  - key_next: sta_sto_flag.
  - Any key clears the idle counter.
  - tick_1hz increments the idle counter. When it reaches IDLE_TIMEOUT: read_flag, go to LIVE.
  - A tick in the same cycle as a key: the key wins and the counter clears.
- VIEW_AUTO:
  - tick_1hz increments the period counter. When it reaches AUTO_PERIOD: sta_sto_flag and the counter clears.
  - key_next: sta_sto_flag immediately and the period counter clears; a coincident period expiry produces no second strobe.
  - key_auto: go to VIEW_MAN, idle counter cleared.
  - key_view: read_flag, go to LIVE.
  - No idle timeout in VIEW_AUTO.
- key_lap in either view state: lap_reject; storage is unchanged.
- stored_cnt never wraps; it stays at MAX_LAPS. Only reset clears it.
- Reset mid-operation, including during a pending_view, returns to the reset state with no strobe emitted.

Decomposition:
- Shared package:
  - state enum (LIVE, VIEW_MAN, VIEW_AUTO);
  - MAX_LAPS and the stored_cnt width constant (5);
  - default AUTO_PERIOD and IDLE_TIMEOUT.
- One sub-module, tick_event_counter: generic tick counter with clear input, parameterised terminal value, and one-cycle done output. Instantiated twice, once for the auto period and once for the idle timeout.

Test Plan:
- Reset, run_en=1, key_lap ×3 -> store_flag pulses 1 cycle after each key; stored_cnt=3; no rejects.
- run_en=1, 17 key_lap pulses -> 16 store_flag pulses; stored_cnt=16; 17th key gives lap_reject and no store_flag. Separately, run_en=0 with key_lap -> lap_reject only.
- stored_cnt=0, key_view -> view_reject, disp_mode stays 0. Then key_lap+key_view in the same cycle with run_en=1 -> store_flag at T+1, read_flag at T+2, disp_mode=1.
- VIEW_MAN with IDLE_TIMEOUT=10: key_next -> one sta_sto_flag; then 10 tick_1hz pulses with no key -> read_flag on the cycle after the 10th tick, state LIVE. A key at tick 9 restarts the count.
- VIEW_AUTO with AUTO_PERIOD=2: 6 ticks -> 3 sta_sto_flag pulses; key_next coincident with the expiring tick -> exactly one strobe; key_auto -> auto_on=0.
- Assert rst_n low while in VIEW_AUTO -> all outputs 0 asynchronously; stored_cnt=0; no strobe after release.
